// File: rtl/flash_arb_pkg.sv
// Shared types and default timing for the NOR flash read arbiter.
package flash_arb_pkg;

  localparam int unsigned FLASH_ADDR_W      = 24;
  localparam int unsigned FLASH_DATA_W      = 16;
  localparam int unsigned FLASH_READ_CYCLES = 8;
  localparam int unsigned FLASH_TURN_CYCLES = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_CAPTURE,
    ST_RECOVER
  } arb_state_e;

endpackage

// File: rtl/flash_read_arbiter_rr.sv
// Combinational round-robin pick: first requesting index after the pointer, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               any_req
);

  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    idx        = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = IDX_W'((32'(pointer) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        found       = 1'b1;
        winner[idx] = 1'b1;
        winner_idx  = idx;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/flash_read_arbiter.sv
// Arbitrates NUM_REQ readers onto one asynchronous NOR flash port.
// Define FLASH_AUDIO_PRIORITY_EN to give requester 0 (PCM fetch) absolute priority.
module flash_read_arbiter
  import flash_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned ADDR_W      = FLASH_ADDR_W,
  parameter int unsigned DATA_W      = FLASH_DATA_W,
  parameter int unsigned READ_CYCLES = FLASH_READ_CYCLES,
  parameter int unsigned TURN_CYCLES = FLASH_TURN_CYCLES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         flash_a,
  output logic                      flash_adv_n,
  output logic                      flash_ce_n,
  output logic                      flash_oe_n,
  output logic                      flash_we_n,
  output logic                      flash_clk,
  input  logic [DATA_W-1:0]         flash_d,
  input  logic                      flash_wait
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned RCNT_W = $clog2(READ_CYCLES + 1);
  localparam int unsigned TCNT_W = $clog2(TURN_CYCLES + 1);

  arb_state_e          state;
  logic [IDX_W-1:0]    pointer;
  logic [NUM_REQ-1:0]  win_q;
  logic [RCNT_W-1:0]   rcnt;
  logic [TCNT_W-1:0]   tcnt;

  logic [NUM_REQ-1:0]  arb_req;
  logic [NUM_REQ-1:0]  rr_winner;
  logic [IDX_W-1:0]    rr_idx;
  logic                rr_any;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic                pick_rr;
  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
  logic                unused_wait;

  // Read-only asynchronous mode: write strobe and burst clock are parked.
  assign flash_we_n  = 1'b1;
  assign flash_clk   = 1'b0;
  assign unused_wait = flash_wait;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_arr[g] = addr[g*ADDR_W +: ADDR_W];
  end

`ifdef FLASH_AUDIO_PRIORITY_EN
  assign arb_req = req & ~NUM_REQ'(1);
`else
  assign arb_req = req;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (arb_req),
    .pointer    (pointer),
    .winner     (rr_winner),
    .winner_idx (rr_idx),
    .any_req    (rr_any)
  );

  // Final winner; with audio priority, requester 0 bypasses the rotation.
  always_comb begin
    pick_onehot = rr_winner;
    pick_idx    = rr_idx;
    pick_any    = rr_any;
    pick_rr     = rr_any;
`ifdef FLASH_AUDIO_PRIORITY_EN
    if (req[0]) begin
      pick_onehot = NUM_REQ'(1);
      pick_idx    = '0;
      pick_any    = 1'b1;
      pick_rr     = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      pointer     <= IDX_W'(NUM_REQ - 1);
      win_q       <= '0;
      rcnt        <= '0;
      tcnt        <= '0;
      gnt         <= '0;
      rvalid      <= '0;
      rdata       <= '0;
      busy        <= 1'b0;
      flash_a     <= '0;
      flash_adv_n <= 1'b1;
      flash_ce_n  <= 1'b1;
      flash_oe_n  <= 1'b1;
    end else begin
      gnt    <= '0;
      rvalid <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state       <= ST_SETUP;
            win_q       <= pick_onehot;
            gnt         <= pick_onehot;
            flash_a     <= addr_arr[pick_idx];
            busy        <= 1'b1;
            flash_ce_n  <= 1'b0;
            flash_adv_n <= 1'b0;
            flash_oe_n  <= 1'b1;
            if (pick_rr) pointer <= pick_idx;
          end
        end
        ST_SETUP: begin
          state       <= ST_ACCESS;
          flash_adv_n <= 1'b1;
          flash_oe_n  <= 1'b0;
          rcnt        <= RCNT_W'(READ_CYCLES);
        end
        // Data is sampled on the edge closing the last access clock.
        ST_ACCESS: begin
          if (rcnt == RCNT_W'(1)) begin
            state      <= ST_CAPTURE;
            rdata      <= flash_d;
            rvalid     <= win_q;
            flash_oe_n <= 1'b1;
          end else begin
            rcnt <= rcnt - RCNT_W'(1);
          end
        end
        ST_CAPTURE: begin
          state      <= ST_RECOVER;
          flash_ce_n <= 1'b1;
          tcnt       <= TCNT_W'(TURN_CYCLES);
        end
        ST_RECOVER: begin
          if (tcnt == TCNT_W'(1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            tcnt <= tcnt - TCNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Bench for flash_read_arbiter: per-read timeline model, directed steps then random traffic.
module tb_flash_read_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 16;
  localparam int RC      = 8;
  localparam int TC      = 1;

  logic                      clk;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic [ADDR_W-1:0]         flash_a;
  logic                      flash_adv_n;
  logic                      flash_ce_n;
  logic                      flash_oe_n;
  logic                      flash_we_n;
  logic                      flash_clk;
  logic [DATA_W-1:0]         flash_d;
  logic                      flash_wait;

  logic [ADDR_W-1:0] a_reg [NUM_REQ];
  int n_cmp;
  int n_err;
  int oe_cnt;

  // Model: m_t is clocks since the grant cycle (-1 = idle).
  int                m_t;
  int                m_win;
  int                m_ptr;
  logic [ADDR_W-1:0] m_a;
  logic [DATA_W-1:0] m_rdata;

  flash_read_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .READ_CYCLES(RC), .TURN_CYCLES(TC)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .gnt(gnt),
    .rvalid(rvalid), .rdata(rdata), .busy(busy), .flash_a(flash_a),
    .flash_adv_n(flash_adv_n), .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n),
    .flash_we_n(flash_we_n), .flash_clk(flash_clk), .flash_d(flash_d),
    .flash_wait(flash_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    addr = '0;
    for (int i = 0; i < NUM_REQ; i++) addr[i*ADDR_W +: ADDR_W] = a_reg[i];
  end

  function automatic logic [DATA_W-1:0] flash_fn(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ {a[23:16], a[7:0]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h t=%0d", tag, obs, exp, m_t);
    end
  endtask

  task automatic model_reset();
    m_t = -1; m_win = 0; m_ptr = NUM_REQ - 1; m_a = '0; m_rdata = '0;
  endtask

  // Advance the model across one rising edge using the inputs held before it.
  task automatic model_edge();
    int best_d;
    int d;
    if (reset) begin
      model_reset();
    end else if (m_t < 0) begin
      if (req != '0) begin
        best_d = NUM_REQ + 1;
        for (int i = 0; i < NUM_REQ; i++) begin
          d = (i - m_ptr - 1 + 2*NUM_REQ) % NUM_REQ;
          if (req[i] && d < best_d) begin best_d = d; m_win = i; end
        end
        m_ptr = m_win;
        m_a   = a_reg[m_win];
        m_t   = 0;
      end
    end else if (m_t == RC + 1 + TC) begin
      m_t = -1;
    end else begin
      m_t++;
      if (m_t == RC + 1) m_rdata = flash_fn(m_a);
    end
  endtask

  task automatic check_all();
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[m_win] = 1'b1;
    chk("gnt",     32'(gnt),         32'((m_t == 0) ? oh : '0));
    chk("rvalid",  32'(rvalid),      32'((m_t == RC + 1) ? oh : '0));
    chk("busy",    32'(busy),        32'(m_t >= 0));
    chk("ce_n",    32'(flash_ce_n),  32'(!(m_t >= 0 && m_t <= RC + 1)));
    chk("oe_n",    32'(flash_oe_n),  32'(!(m_t >= 1 && m_t <= RC)));
    chk("adv_n",   32'(flash_adv_n), 32'(m_t != 0));
    chk("flash_a", 32'(flash_a),     32'(m_a));
    chk("rdata",   32'(rdata),       32'(m_rdata));
    chk("we_n",    32'(flash_we_n),  32'h1);
    chk("fclk",    32'(flash_clk),   32'h0);
  endtask

  // Flash device: valid data only after oe_n has been low for 6 full clocks.
  task automatic drive_flash();
    if (flash_oe_n == 1'b0) oe_cnt++;
    else oe_cnt = 0;
    flash_d = (oe_cnt >= 7) ? flash_fn(flash_a) : DATA_W'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
    drive_flash();
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic random_drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        if (gnt[i] || $urandom_range(0, 99) < 3) req[i] = 1'b0;
      end else begin
        a_reg[i] = ADDR_W'($urandom);
        if ($urandom_range(0, 99) < 20) req[i] = 1'b1;
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; oe_cnt = 0;
    reset = 1'b0; req = '0; flash_d = '0; flash_wait = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) a_reg[i] = '0;
    model_reset();

    // Power-on reset.
    #2 reset = 1'b1;
    #1 check_all();
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();

    // Single read from requester 1.
    a_reg[1] = 24'h000123;
    req[1] = 1'b1;
    repeat (16) begin
      tick();
      if (gnt[1]) req[1] = 1'b0;
    end

    // Continuous contention: grants must alternate.
    a_reg[0] = 24'h00AAAA;
    a_reg[1] = 24'h005555;
    req = '1;
    repeat (60) tick();
    req = '0;
    repeat (14) tick();

    // Requester 1 pulses only while a requester-0 read is in flight.
    a_reg[0] = 24'h0ABCDE;
    req[0] = 1'b1;
    for (int n = 0; n < 20 && !gnt[0]; n++) tick();
    req[0] = 1'b0;
    repeat (3) tick();
    req[1] = 1'b1;
    repeat (3) tick();
    req[1] = 1'b0;
    repeat (12) tick();

    // Reset mid-access after a requester-0 grant; requester 0 must win again.
    a_reg[0] = 24'h123456;
    req[0] = 1'b1;
    for (int n = 0; n < 20 && !gnt[0]; n++) tick();
    req[0] = 1'b0;
    repeat (3) tick();
    a_reg[1] = 24'h654321;
    req = '1;
    async_reset();
    repeat (30) tick();
    req = '0;
    repeat (14) tick();

    // Random traffic with withdrawals and address churn on idle requesters.
    repeat (800) begin
      tick();
      random_drive();
    end
    req = '0;
    repeat (15) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
